// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with memory-ready handshake and optional grant timeout.
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to revoke grants held for TIMEOUT_CYCLES.
module bus_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] Bus_RQ,
  input  logic                 Bus_Mem_Ready,
  output logic [NUM_CORES-1:0] Bus_GRANT,
  output logic [2:0]           Grant_Owner,
  output logic                 Bus_Busy,
  output logic                 Timeout_Flag
);
  typedef enum logic [1:0] {IDLE, GRANTED, WAIT_MEM_LOW} state_t;
  if (NUM_CORES < 2 || NUM_CORES > 8 || TIMEOUT_CYCLES < 1) begin : g_chk
    $error("bus_arbiter: illegal parameters");
  end
  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [2:0]           owner_q, owner_d, win;
  logic                 busy_q, own_rq;
  // Walk distances from farthest to nearest so the nearest asserted requester wins.
  always_comb begin
    win = owner_q;
    for (int i = NUM_CORES; i >= 1; i--)
      for (int j = 0; j < NUM_CORES; j++)
        if (Bus_RQ[j] && j == (int'(owner_q) + i) % NUM_CORES) win = 3'(j);
  end
  assign own_rq = |(Bus_RQ & grant_q);
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tflag_q, tflag_d;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    cnt_d   = '0;
    tflag_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (|Bus_RQ && !Bus_Mem_Ready) begin
        state_d = GRANTED;
        owner_d = win;
        grant_d = {{(NUM_CORES-1){1'b0}}, 1'b1} << win;
      end
      GRANTED: if (!own_rq) begin
        state_d = WAIT_MEM_LOW;
        grant_d = '0;
      end
`ifdef BUS_ARBITER_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = WAIT_MEM_LOW;
        grant_d = '0;
        tflag_d = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
`endif
      WAIT_MEM_LOW: if (!Bus_Mem_Ready) state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= 3'(NUM_CORES - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= state_d != IDLE;
    end
  end
`ifdef BUS_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end
  assign Timeout_Flag = tflag_q;
`else
  assign Timeout_Flag = 1'b0;
`endif
  assign Bus_GRANT   = grant_q;
  assign Grant_Owner = owner_q;
  assign Bus_Busy    = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed per-cycle vectors with a queue scoreboard checked by a separate monitor.
module tb_bus_arbiter;
  typedef struct packed {
    logic [3:0] g;
    logic [2:0] o;
    logic       b;
    logic       t;
  } exp_t;
  logic       clk = 1'b0, reset = 1'b1, Bus_Mem_Ready = 1'b0;
  logic [3:0] Bus_RQ = '0, Bus_GRANT;
  logic [2:0] Grant_Owner;
  logic       Bus_Busy, Timeout_Flag;
  exp_t       sb[$];
  int         ncmp = 0, nbad = 0, nstep = 0;
  bit         done = 1'b0;
  bus_arbiter #(.NUM_CORES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .Bus_RQ(Bus_RQ), .Bus_Mem_Ready(Bus_Mem_Ready),
    .Bus_GRANT(Bus_GRANT), .Grant_Owner(Grant_Owner), .Bus_Busy(Bus_Busy),
    .Timeout_Flag(Timeout_Flag)
  );
  always #5 clk = ~clk;
  // Drive one cycle of inputs and queue the outputs expected after the edge that samples them.
  task automatic step(input logic r, input logic [3:0] rq, input logic mr,
                      input logic [3:0] g, input int o, input logic b, input logic t);
    reset = r;
    Bus_RQ = rq;
    Bus_Mem_Ready = mr;
    sb.push_back('{g: g, o: 3'(o), b: b, t: t});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e, a;
      e = sb.pop_front();
      a = '{g: Bus_GRANT, o: Grant_Owner, b: Bus_Busy, t: Timeout_Flag};
      nstep++;
      ncmp++;
      if (a !== e) begin
        nbad++;
        $display("FAIL cycle%0d: got grant=%b owner=%0d busy=%b tflag=%b, want grant=%b owner=%0d busy=%b tflag=%b",
                 nstep, a.g, a.o, a.b, a.t, e.g, e.o, e.b, e.t);
      end
      ncmp++;
      if (!$onehot0(Bus_GRANT)) begin
        nbad++;
        $display("FAIL onehot cycle%0d: got grant=%b, want one-hot or zero", nstep, Bus_GRANT);
      end
    end
  end
  initial begin
    step(1, 4'b0000, 0, 4'b0000, 3, 0, 0);
    step(1, 4'b0000, 0, 4'b0000, 3, 0, 0);
    // single request, release, back to idle
    step(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
    step(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // round robin with all cores requesting
    step(1, 4'b0000, 0, 4'b0000, 3, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 4'b1111, 0, 4'b0001 << k, k, 1, 0);
      step(0, 4'b1111, 0, 4'b0001 << k, k, 1, 0);
      step(0, 4'b1111 & ~(4'b0001 << k), 0, 4'b0000, k, 1, 0);
      step(0, 4'b1111, 0, 4'b0000, k, 0, 0);
    end
    step(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // memory-ready blocks arbitration
    repeat (5) step(0, 4'b0100, 1, 4'b0000, 0, 0, 0);
    step(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    // release while memory still ready: wait in WAIT_MEM_LOW
    step(0, 4'b0000, 1, 4'b0000, 2, 1, 0);
    repeat (3) step(0, 4'b0001, 1, 4'b0000, 2, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 2, 0, 0);
    // reset mid-grant
    step(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step(1, 4'b0100, 0, 4'b0000, 3, 0, 0);
    step(0, 4'b0101, 0, 4'b0001, 0, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // long hold by core 1
`ifdef BUS_ARBITER_TIMEOUT_EN
    repeat (8) step(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    step(0, 4'b0010, 0, 4'b0000, 1, 1, 1);
    step(0, 4'b0010, 0, 4'b0000, 1, 0, 0);
    step(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
`else
    repeat (110) step(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 1, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
`endif
    repeat (4) @(posedge clk);
    ncmp++;
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
